// File: rtl/imem_fetch_port.sv
// Instruction memory behind a one-outstanding valid/ready fetch port, with boot-load writes and fault reporting.
// Latency: resp_valid is set on edge acceptance+LATENCY-1. The next accept can follow the response handshake by one cycle.
// Backpressure: the response is held in RESP until resp_ready. req_ready is low whenever not IDLE or while loading.
module imem_fetch_port #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                LATENCY  = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_fault,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     busy
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              fetch_fault;
    logic              accept;

    // Range check uses the full address so high bits never alias onto low words.
    assign word_idx    = req_addr >> 2;
    assign rd_idx      = req_addr[IDX_W+1:2];
    assign fetch_fault = (req_addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(DEPTH));

    assign req_ready = (state == IDLE) && !ld_en && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);

    // Contents survive reset; only the boot-load port writes the array.
    always_ff @(posedge clk) begin
        if (ld_en && !reset) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= NOP_WORD;
            resp_fault <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_data  <= fetch_fault ? NOP_WORD : mem[rd_idx];
                        resp_fault <= fetch_fault;
                        lat_cnt    <= '0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == WAIT_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        lat_cnt    <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
